shifter_right_logical: RTL and testbench

//   Registered logical right shifter for the RV32I datapath (SRL/SRLI in the ALU).

---
 rtl/alu_pkg.sv | 10 +
 rtl/shifter_right_logical_if.sv | 16 +
 rtl/shifter_rl_core.sv | 31 +++
 rtl/shifter_right_logical.sv | 54 +++++
 tb/tb_shifter_right_logical.sv | 128 ++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath widths and the word type.
// XLEN and SHAMT_W are the defaults for the shifter parameters.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef logic [XLEN-1:0] word_t;

endpackage : alu_pkg

// File: rtl/shifter_right_logical_if.sv
// Operand bundle feeding the right shifter: data, shift amount and qualifier.
// The core modport sees only the operand fields, because the barrel network has no use for the qualifier.
interface shifter_right_logical_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
);

  logic [DATA_WIDTH-1:0]  data;
  logic [SHIFT_WIDTH-1:0] shift_value;
  logic                   valid;

  modport master (output data, output shift_value, output valid);
  modport slave  (input  data, input  shift_value, input  valid);
  modport core   (input  data, input  shift_value);

endinterface : shifter_right_logical_if

// File: rtl/shifter_rl_core.sv
// Combinational log2 barrel network for a logical right shift with zero fill.
// Stage k shifts by 2**k when shift bit k is set; stages that would shift past the width produce zero.
module shifter_rl_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = XLEN,
  parameter int SHIFT_WIDTH = SHAMT_W
) (
  shifter_right_logical_if.core  op_if,
  output logic [DATA_WIDTH-1:0]  result_o
);

  logic [DATA_WIDTH-1:0] stage [SHIFT_WIDTH+1];

  assign stage[0] = op_if.data;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    localparam int SH = 2 ** k;
    if (SH < DATA_WIDTH) begin : g_shift
      assign stage[k+1] = op_if.shift_value[k]
                          ? {{SH{1'b0}}, stage[k][DATA_WIDTH-1:SH]}
                          : stage[k];
    end else begin : g_flush
      // A 2**k step at or beyond the width clears every bit.
      assign stage[k+1] = op_if.shift_value[k] ? '0 : stage[k];
    end
  end

  assign result_o = stage[SHIFT_WIDTH];

endmodule : shifter_rl_core

// File: rtl/shifter_right_logical.sv
// Registered logical right shifter (SRL/SRLI): a barrel core followed by a one-cycle output register.
// The datapath is never gated by valid_i; valid_o qualifies data_o.
module shifter_right_logical
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = XLEN,
  parameter int SHIFT_WIDTH = SHAMT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHIFT_WIDTH-1:0] shift_value_i,
  input  logic                   valid_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   valid_o
);

  shifter_right_logical_if #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) op_if ();

  assign op_if.data        = data_i;
  assign op_if.shift_value = shift_value_i;
  assign op_if.valid       = valid_i;

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  valid_d, valid_q;

  shifter_rl_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_core (
    .op_if    (op_if.core),
    .result_o (data_d)
  );

  assign valid_d = op_if.valid;

  // Reset wins over the inputs and drops any in-flight result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule : shifter_right_logical

// File: tb/tb_shifter_right_logical.sv
// Scoreboard bench for shifter_right_logical: the driver queues the expected registered output,
// the monitor pops one entry per edge and compares data_o and valid_o.
module tb_shifter_right_logical;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shifter_right_logical_if #(.DATA_WIDTH(32), .SHIFT_WIDTH(5)) bus ();

  logic [31:0] data_o;
  logic        valid_o;

  shifter_right_logical #(32, 5) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .data_i        (bus.data),
    .shift_value_i (bus.shift_value),
    .valid_i       (bus.valid),
    .data_o        (data_o),
    .valid_o       (valid_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        valid;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] ex;
  } vec_t;

  vec_t dir_vec[$];

  task automatic issue(input logic r, input logic [31:0] d, input logic [4:0] s,
                       input logic v, input logic [31:0] ed, input logic ev, input string nm);
    @(negedge clk);
    rst             = r;
    bus.data        = d;
    bus.shift_value = s;
    bus.valid       = v;
    sb.push_back('{ed, ev, nm});
  endtask

  // Monitor: each rising edge registers exactly one issued operand.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (data_o !== e.data || valid_o !== e.valid) begin
          errors++;
          $display("FAIL %s: got data_o=%h valid_o=%b, expected data_o=%h valid_o=%b",
                   e.name, data_o, valid_o, e.data, e.valid);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  s;
    logic        v;

    rst             = 1'b1;
    bus.data        = 32'hDEAD_BEEF;
    bus.shift_value = 5'd3;
    bus.valid       = 1'b1;

    dir_vec.push_back('{32'h0000_0001, 5'd0,  32'h0000_0001});
    dir_vec.push_back('{32'h0000_0001, 5'd1,  32'h0000_0000});
    dir_vec.push_back('{32'h0000_0001, 5'd4,  32'h0000_0000});
    dir_vec.push_back('{32'h0000_0001, 5'd10, 32'h0000_0000});
    dir_vec.push_back('{32'hFEDC_BA98, 5'd0,  32'hFEDC_BA98});
    dir_vec.push_back('{32'hFEDC_BA98, 5'd1,  32'h7F6E_5D4C});
    dir_vec.push_back('{32'hFEDC_BA98, 5'd4,  32'h0FED_CBA9});
    dir_vec.push_back('{32'hFEDC_BA98, 5'd10, 32'h003F_B72E});
    dir_vec.push_back('{32'hFEDC_BA98, 5'd30, 32'h0000_0003});
    dir_vec.push_back('{32'hFEDC_BA98, 5'd31, 32'h0000_0001});
    dir_vec.push_back('{32'h8000_0000, 5'd31, 32'h0000_0001});
    dir_vec.push_back('{32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF});
    dir_vec.push_back('{32'h1234_5678, 5'd8,  32'h0012_3456});

    // Reset held two cycles with live inputs, then released.
    issue(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h0, 1'b0, "reset_0");
    issue(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0, 1'b0, "reset_1");
    issue(1'b0, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h0DEA_DBEE, 1'b1, "post_reset");

    foreach (dir_vec[i])
      issue(1'b0, dir_vec[i].d, dir_vec[i].s, 1'b1, dir_vec[i].ex, 1'b1, "directed");

    // Back-to-back with valid toggling; data still updates when valid_i is low.
    issue(1'b0, 32'hA5A5_A5A5, 5'd1, 1'b0, 32'h52D2_D2D2, 1'b0, "b2b_0");
    issue(1'b0, 32'hF000_000F, 5'd3, 1'b1, 32'h1E00_0001, 1'b1, "b2b_1");
    issue(1'b0, 32'h8000_0001, 5'd2, 1'b0, 32'h2000_0000, 1'b0, "b2b_2");
    issue(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0,         1'b0, "midstream_reset");
    issue(1'b0, 32'h0000_FF00, 5'd8, 1'b1, 32'h0000_00FF, 1'b1, "b2b_resume");
    issue(1'b0, 32'h7FFF_FFFF, 5'd31, 1'b0, 32'h0000_0000, 1'b0, "b2b_msb_clear");

    for (int i = 0; i < 10000; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      v = 1'($urandom_range(0, 1));
      issue(1'b0, d, s, v, d >> s, v, "random");
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shifter_right_logical
